ysyx_24100006_wbu: RTL and testbench

//   Write-back stage. Sits directly downstream of the memory-access stage and

---
 rtl/ysyx_24100006_wbu.sv | 159 +++++++++++++++
 tb/tb_ysyx_24100006_wbu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100006_wbu.sv
// Write-back stage: latches one instruction per handshake, then spends one commit cycle issuing GPR/CSR/trap writes.
// Optional macro YSYX_24100006_WBU_RETIRE_CNT_EN adds a 64-bit retire counter output.
module ysyx_24100006_wbu #(
    parameter int GPR_AW = 4,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_valid,
    output logic              wb_ready,
    input  logic [31:0]       pc_W,
    input  logic [31:0]       sext_imm_W,
    input  logic [31:0]       alu_result_W,
    input  logic [31:0]       rs1_data_W,
    input  logic [31:0]       rdata_csr_W,
    input  logic [31:0]       Mem_rdata_extend,
    input  logic [GPR_AW-1:0] rd_W,
    input  logic [CSR_AW-1:0] csr_addr_W,
    input  logic              irq_W,
    input  logic [7:0]        irq_no_W,
    input  logic              Gpr_Write_W,
    input  logic              Csr_Write_W,
    input  logic [2:0]        Gpr_Write_RD_W,
    input  logic [1:0]        Csr_Write_RD_W,
    output logic              gpr_wen,
    output logic [GPR_AW-1:0] gpr_waddr,
    output logic [31:0]       gpr_wdata,
    output logic              csr_wen,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [31:0]       csr_wdata,
    output logic              trap_wen,
    output logic [31:0]       trap_mepc,
    output logic [31:0]       trap_mcause,
    output logic              wb_done,
    output logic              wb_state
`ifdef YSYX_24100006_WBU_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where mem_valid && wb_ready;
    // upstream must hold its payload stable until that edge.
    typedef enum logic {S_IDLE, S_COMMIT} state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   commit;

    logic [31:0]       pc_q, imm_q, alu_q, rs1_q, csr_old_q, mem_q;
    logic [GPR_AW-1:0] rd_q;
    logic [CSR_AW-1:0] csr_addr_q;
    logic              irq_q, gpr_we_q, csr_we_q;
    logic [7:0]        irq_no_q;
    logic [2:0]        gpr_sel_q;
    logic [1:0]        csr_sel_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        wb_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                wb_ready = 1'b1;
                if (mem_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                commit    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wb_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            imm_q      <= '0;
            alu_q      <= '0;
            rs1_q      <= '0;
            csr_old_q  <= '0;
            mem_q      <= '0;
            rd_q       <= '0;
            csr_addr_q <= '0;
            irq_q      <= 1'b0;
            irq_no_q   <= '0;
            gpr_we_q   <= 1'b0;
            csr_we_q   <= 1'b0;
            gpr_sel_q  <= '0;
            csr_sel_q  <= '0;
        end else if (accept) begin
            pc_q       <= pc_W;
            imm_q      <= sext_imm_W;
            alu_q      <= alu_result_W;
            rs1_q      <= rs1_data_W;
            csr_old_q  <= rdata_csr_W;
            mem_q      <= Mem_rdata_extend;
            rd_q       <= rd_W;
            csr_addr_q <= csr_addr_W;
            irq_q      <= irq_W;
            irq_no_q   <= irq_no_W;
            gpr_we_q   <= Gpr_Write_W;
            csr_we_q   <= Csr_Write_W;
            gpr_sel_q  <= Gpr_Write_RD_W;
            csr_sel_q  <= Csr_Write_RD_W;
        end
    end

    always_comb begin
        gpr_wdata = '0;
        case (gpr_sel_q)
            3'b000:  gpr_wdata = alu_q;
            3'b001:  gpr_wdata = mem_q;
            3'b010:  gpr_wdata = pc_q + 32'd4;
            3'b011:  gpr_wdata = imm_q;
            3'b100:  gpr_wdata = csr_old_q;
            default: gpr_wdata = '0;
        endcase
    end

    always_comb begin
        csr_wdata = rs1_q;
        case (csr_sel_q)
            2'b00:   csr_wdata = rs1_q;
            2'b01:   csr_wdata = csr_old_q | rs1_q;
            2'b10:   csr_wdata = csr_old_q & ~rs1_q;
            default: csr_wdata = rs1_q;
        endcase
    end

    // A trapping instruction never performs its own CSR write; mepc/mcause take priority.
    assign gpr_wen     = commit && gpr_we_q && (rd_q != '0);
    assign gpr_waddr   = rd_q;
    assign csr_wen     = commit && csr_we_q && !irq_q;
    assign csr_waddr   = csr_addr_q;
    assign trap_wen    = commit && irq_q;
    assign trap_mepc   = pc_q;
    assign trap_mcause = {24'b0, irq_no_q};
    assign wb_done     = commit;

`ifdef YSYX_24100006_WBU_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      retire_cnt <= '0;
        else if (commit) retire_cnt <= retire_cnt + 64'd1;
    end
`endif

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Scoreboard bench for the write-back stage: directed instructions with hand-computed write results.
module tb_ysyx_24100006_wbu;

    localparam int W = 1 + 4 + 32 + 1 + 12 + 32 + 1 + 32 + 32;

    logic        clk, reset, mem_valid, wb_ready;
    logic [31:0] pc_W, sext_imm_W, alu_result_W, rs1_data_W, rdata_csr_W, Mem_rdata_extend;
    logic [3:0]  rd_W;
    logic [11:0] csr_addr_W;
    logic        irq_W;
    logic [7:0]  irq_no_W;
    logic        Gpr_Write_W, Csr_Write_W;
    logic [2:0]  Gpr_Write_RD_W;
    logic [1:0]  Csr_Write_RD_W;
    logic        gpr_wen, csr_wen, trap_wen, wb_done, wb_state;
    logic [3:0]  gpr_waddr;
    logic [11:0] csr_waddr;
    logic [31:0] gpr_wdata, csr_wdata, trap_mepc, trap_mcause;
`ifdef YSYX_24100006_WBU_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    logic [W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int commits = 0;

    ysyx_24100006_wbu dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .wb_ready(wb_ready),
        .pc_W(pc_W), .sext_imm_W(sext_imm_W), .alu_result_W(alu_result_W),
        .rs1_data_W(rs1_data_W), .rdata_csr_W(rdata_csr_W), .Mem_rdata_extend(Mem_rdata_extend),
        .rd_W(rd_W), .csr_addr_W(csr_addr_W), .irq_W(irq_W), .irq_no_W(irq_no_W),
        .Gpr_Write_W(Gpr_Write_W), .Csr_Write_W(Csr_Write_W),
        .Gpr_Write_RD_W(Gpr_Write_RD_W), .Csr_Write_RD_W(Csr_Write_RD_W),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .trap_wen(trap_wen), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
        .wb_done(wb_done), .wb_state(wb_state)
`ifdef YSYX_24100006_WBU_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack(input logic gw, input logic [3:0] ga, input logic [31:0] gd,
                                          input logic cw, input logic [11:0] ca, input logic [31:0] cd,
                                          input logic tw, input logic [31:0] tm, input logic [31:0] tc);
        // Address/data only matter while their strobe is high.
        return {gw, ga & {4{gw}}, gd & {32{gw}}, cw, ca & {12{cw}}, cd & {32{cw}},
                tw, tm & {32{tw}}, tc & {32{tw}}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // driver tasks
    task automatic set_in(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                          input logic [31:0] rs1, input logic [31:0] csr_old, input logic [31:0] mrd,
                          input logic [3:0] rd, input logic [11:0] caddr, input logic irq,
                          input logic [7:0] irq_no, input logic gw, input logic cw,
                          input logic [2:0] gsel, input logic [1:0] csel);
        pc_W = pc; sext_imm_W = imm; alu_result_W = alu; rs1_data_W = rs1;
        rdata_csr_W = csr_old; Mem_rdata_extend = mrd; rd_W = rd; csr_addr_W = caddr;
        irq_W = irq; irq_no_W = irq_no; Gpr_Write_W = gw; Csr_Write_W = cw;
        Gpr_Write_RD_W = gsel; Csr_Write_RD_W = csel;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wb_ready && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (!wb_ready) begin
            fails++;
            $display("FAIL ready_timeout: wb_ready=%0b expected 1", wb_ready);
        end
    endtask

    task automatic send(input logic [W-1:0] e);
        wait_ready();
        exp_q.push_back(e);
        mem_valid = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            if (wb_done) begin
                logic [W-1:0] act, e;
                commits++;
                act = pack(gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata,
                           trap_wen, trap_mepc, trap_mcause);
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_commit: got 0x%0h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL commit_writes: got 0x%0h expected 0x%0h", act, e);
                    end
                end
                check("ready_low_in_commit", {63'd0, wb_ready}, 64'd0);
            end else if (gpr_wen || csr_wen || trap_wen) begin
                tests++;
                fails++;
                $display("FAIL strobe_without_done: strobes=%0b%0b%0b expected 000", gpr_wen, csr_wen, trap_wen);
            end
        end
    end

    initial begin
        int n;
        reset = 1'b0;
        mem_valid = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        check("rst_ready", {63'd0, wb_ready}, 64'd1);
        check("rst_strobes", {60'd0, gpr_wen, csr_wen, trap_wen, wb_done}, 64'd0);
        check("rst_gpr_data", {28'd0, gpr_waddr, gpr_wdata}, 64'd0);
        check("rst_csr_data", {20'd0, csr_waddr, csr_wdata}, 64'd0);
        check("rst_trap_data", {trap_mepc, trap_mcause}, 64'd0);
`ifdef YSYX_24100006_WBU_RETIRE_CNT_EN
        check("rst_retire_cnt", retire_cnt, 64'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // pc, imm, alu, rs1, csr_old, mrd, rd, caddr, irq, irq_no, gw, cw, gsel, csel
        set_in(32'h100, 0, 32'h1234, 0, 0, 0, 4'd5, 0, 0, 0, 1, 0, 3'b000, 2'b00);
        send(pack(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0));
        set_in(32'h104, 0, 32'h77, 0, 0, 0, 4'd0, 0, 0, 0, 1, 0, 3'b000, 2'b00);
        send(pack(0, 0, 0, 0, 0, 0, 0, 0, 0));
        set_in(32'hFFFFFFFC, 0, 32'h5, 0, 0, 0, 4'd1, 0, 0, 0, 1, 0, 3'b010, 2'b00);
        send(pack(1, 1, 32'h0, 0, 0, 0, 0, 0, 0));
        set_in(32'h108, 0, 0, 32'h0F, 32'hF0, 0, 4'd2, 12'h300, 0, 0, 0, 1, 3'b000, 2'b01);
        send(pack(0, 0, 0, 1, 12'h300, 32'hFF, 0, 0, 0));
        set_in(32'h80000010, 0, 32'h55, 32'h1, 32'h2, 0, 4'd10, 12'h342, 1, 8'h0B, 1, 1, 3'b000, 2'b00);
        send(pack(1, 10, 32'h55, 0, 0, 0, 1, 32'h80000010, 32'h0000000B));
        set_in(32'h10C, 0, 32'h1, 0, 0, 32'hDEADBEEF, 4'd3, 0, 0, 0, 1, 0, 3'b001, 2'b00);
        send(pack(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
        set_in(32'h110, 32'hFFFFF800, 32'h1, 0, 0, 0, 4'd15, 0, 0, 0, 1, 0, 3'b011, 2'b00);
        send(pack(1, 15, 32'hFFFFF800, 0, 0, 0, 0, 0, 0));
        set_in(32'h114, 0, 32'h1, 0, 32'h12345678, 0, 4'd7, 0, 0, 0, 1, 0, 3'b100, 2'b00);
        send(pack(1, 7, 32'h12345678, 0, 0, 0, 0, 0, 0));
        set_in(32'h118, 32'h3, 32'h99, 0, 32'h4, 32'h5, 4'd2, 0, 0, 0, 1, 0, 3'b101, 2'b00);
        send(pack(1, 2, 32'h0, 0, 0, 0, 0, 0, 0));
        set_in(32'h11C, 0, 32'h1, 32'h0F, 32'hFF, 0, 4'd4, 12'h341, 0, 0, 0, 1, 3'b000, 2'b10);
        send(pack(0, 0, 0, 1, 12'h341, 32'hF0, 0, 0, 0));
        set_in(32'h120, 0, 32'h1, 32'hCAFE, 32'hFFFF0000, 0, 4'd6, 12'h305, 0, 0, 1, 1, 3'b000, 2'b11);
        send(pack(1, 6, 32'h1, 1, 12'h305, 32'hCAFE, 0, 0, 0));
        set_in(32'h124, 0, 32'h1, 32'h1111, 32'h2222, 0, 4'd6, 12'h300, 0, 0, 0, 1, 3'b000, 2'b00);
        send(pack(0, 0, 0, 1, 12'h300, 32'h1111, 0, 0, 0));

        // drain before the reset test
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain1", exp_q.size(), 64'd0);
`ifdef YSYX_24100006_WBU_RETIRE_CNT_EN
        check("retire_cnt_12", retire_cnt, 64'd12);
`endif

        // mem_valid held high; reset hits the second commit
        wait_ready();
        set_in(32'h200, 0, 32'hA1, 0, 0, 0, 4'd8, 0, 0, 0, 1, 0, 3'b000, 2'b00);
        exp_q.push_back(pack(1, 8, 32'hA1, 0, 0, 0, 0, 0, 0));
        mem_valid = 1'b1;
        @(posedge clk); #1;
        set_in(32'h204, 0, 32'hB2, 0, 0, 0, 4'd9, 12'h300, 1, 8'h03, 1, 1, 3'b000, 2'b00);
        @(posedge clk); #1;
        check("held_valid_ignored_in_commit", {63'd0, wb_ready}, 64'd1);
        @(posedge clk); #1;
        check("second_commit_strobes", {61'd0, gpr_wen, trap_wen, wb_done}, 64'd7);
        #1 reset = 1'b0;
        #1;
        check("async_rst_strobes", {60'd0, gpr_wen, csr_wen, trap_wen, wb_done}, 64'd0);
        check("async_rst_ready", {63'd0, wb_ready}, 64'd1);
`ifdef YSYX_24100006_WBU_RETIRE_CNT_EN
        check("async_rst_retire_cnt", retire_cnt, 64'd0);
`endif
        set_in(32'h208, 0, 32'hC3, 0, 0, 0, 4'd11, 0, 0, 0, 1, 0, 3'b000, 2'b00);
        exp_q.push_back(pack(1, 11, 32'hC3, 0, 0, 0, 0, 0, 0));
        #1 reset = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain2", exp_q.size(), 64'd0);
        check("commit_count", commits, 64'd14);
`ifdef YSYX_24100006_WBU_RETIRE_CNT_EN
        check("retire_cnt_after_reset", retire_cnt, 64'd1);
`endif
        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
